// File: rtl/usb_port_arbiter_if.sv
// Downstream port lanes and the shared upstream serial
// path between the lanes and usb_port_arbiter.
interface usb_port_arbiter_if #(
  parameter int N     = 2,
  parameter int IDX_W = 1
);
  logic [N-1:0]     port_req;
  logic [N-1:0]     port_data;
  logic [N-1:0]     port_val;
  logic [N-1:0]     port_last;
  logic [N-1:0]     port_grant;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  logic             up_data;
  logic             up_val;
  logic             up_last;
  logic             xfer_abort;
  logic [15:0]      xfer_bits;

  modport slave (
    input  port_req,
    input  port_data,
    input  port_val,
    input  port_last,
    output port_grant,
    output grant_idx,
    output busy,
    output up_data,
    output up_val,
    output up_last,
    output xfer_abort,
    output xfer_bits
  );

  modport master (
    output port_req,
    output port_data,
    output port_val,
    output port_last,
    input  port_grant,
    input  grant_idx,
    input  busy,
    input  up_data,
    input  up_val,
    input  up_last,
    input  xfer_abort,
    input  xfer_bits
  );
endinterface

// File: rtl/usb_port_arbiter.sv
// Round-robin owner of the shared upstream serial path:
// one downstream port per packet, gap between grants.
module usb_port_arbiter #(
  parameter int NUM_USB_DEVICES = 2,
  parameter int IPG_CYCLES      = 2,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int IDX_W = (NUM_USB_DEVICES > 1) ?
                        $clog2(NUM_USB_DEVICES) : 1
) (
  input  logic              clock,
  input  logic              reset,
  usb_port_arbiter_if.slave bus
);
  localparam int N  = NUM_USB_DEVICES;
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(IPG_CYCLES + 1);
  localparam int PW = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [15:0]      bits_q, bits_d;
  logic [15:0]      xbits_q, xbits_d;
  logic [15:0]      bits_inc;
  logic [SW-1:0]    stall_q, stall_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             abort_q, abort_d;
  logic             pick_hit;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             busy;
  logic             sel_req;
  logic             end_ok;
  logic             timeout;
  logic             drop;

  assign busy    = (state_q == S_GRANT);
  assign sel_req = bus.port_req[idx_q];

  assign bus.up_data = busy & bus.port_data[idx_q];
  assign bus.up_val  = busy & bus.port_val[idx_q];
  assign bus.up_last = busy & bus.port_last[idx_q];

  assign bus.port_grant = grant_q;
  assign bus.grant_idx  = idx_q;
  assign bus.busy       = busy;
  assign bus.xfer_abort = abort_q;
  assign bus.xfer_bits  = xbits_q;

  assign end_ok  = bus.up_val & bus.up_last;
  assign timeout = ~bus.up_val &
                   (stall_q == SW'(TIMEOUT_CYCLES - 1));
  assign drop    = ~sel_req;

  assign bits_inc = (bus.up_val && bits_q != 16'hFFFF) ?
                    bits_q + 16'd1 : bits_q;

  assign idx_nxt = (idx_q == IDX_W'(N - 1)) ?
                   '0 : idx_q + 1'b1;

  // Nearest requester at or above rr_q, wrapping past N-1.
  always_comb begin : pick_p
    logic [PW-1:0] jw;
    logic [PW-1:0] rw;
    logic [PW-1:0] off;
    logic [PW-1:0] best;
    pick_hit = 1'b0;
    pick_idx = rr_q;
    best     = '0;
    rw       = PW'(rr_q);
    for (int j = 0; j < N; j++) begin
      jw  = PW'(j);
      off = (jw >= rw) ? jw - rw : jw + PW'(N) - rw;
      if (bus.port_req[j] && (!pick_hit || off < best)) begin
        pick_hit = 1'b1;
        best     = off;
        pick_idx = IDX_W'(j);
      end
    end
  end

  // Next state, counters and end-of-grant bookkeeping.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    bits_d  = bits_q;
    xbits_d = xbits_q;
    stall_d = stall_q;
    gap_d   = gap_q;
    abort_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_hit) begin
          state_d = S_GRANT;
          idx_d   = pick_idx;
          bits_d  = '0;
          stall_d = '0;
        end
      end
      S_GRANT: begin
        bits_d  = bits_inc;
        stall_d = bus.up_val ? '0 : stall_q + 1'b1;
        if (end_ok || timeout || drop) begin
          state_d = S_GAP;
          gap_d   = '0;
          xbits_d = bits_inc;
          abort_d = ~end_ok;
          rr_d    = idx_nxt;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(IPG_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    grant_d = (state_d == S_GRANT) ?
              (N'(1) << idx_d) : '0;
  end

  // State and datapath registers, synchronous clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      bits_q  <= '0;
      xbits_q <= '0;
      stall_q <= '0;
      gap_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      bits_q  <= bits_d;
      xbits_q <= xbits_d;
      stall_q <= stall_d;
      gap_q   <= gap_d;
      abort_q <= abort_d;
    end
  end
endmodule

// File: tb/tb_usb_port_arbiter.sv
// Scoreboard bench for usb_port_arbiter: expected packet
// outcomes are queued at grant and popped at grant end.
module tb_usb_port_arbiter;
  localparam int NP  = 2;
  localparam int IPG = 2;
  localparam int TMO = 64;

  typedef struct {
    int port;
    int bits;
    bit abort;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   m_rr  = 0;
  exp_t sb[$];

  usb_port_arbiter_if #(.N(NP), .IDX_W(1)) bus ();

  usb_port_arbiter #(
    .NUM_USB_DEVICES(NP),
    .IPG_CYCLES(IPG),
    .TIMEOUT_CYCLES(TMO),
    .IDX_W(1)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference round-robin choice.
  function automatic int pick(input logic [1:0] req,
                              input int rr);
    for (int i = 0; i < NP; i++) begin
      int k;
      k = (rr + i) % NP;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic wait_grant(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      #1;
      lat++;
    end while (bus.busy !== 1'b1 && lat < 100);
  endtask

  task automatic send_bits(input int p, input int n,
                           input bit with_last);
    logic [1:0] oh;
    oh = 2'b01 << p;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      bus.port_data = 2'($urandom_range(0, 3));
      bus.port_val  = oh | (~oh & 2'($urandom_range(0, 3)));
      bus.port_last = (with_last && i == n - 1) ? oh :
                      (~oh & 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic clear_lanes();
    bus.port_data = '0;
    bus.port_val  = '0;
    bus.port_last = '0;
  endtask

  task automatic test_reset();
    bus.port_req = '0;
    clear_lanes();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if ({bus.port_grant, bus.busy, bus.grant_idx,
         bus.xfer_abort, bus.xfer_bits} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: grant=%b busy=%b idx=%b abort=%b bits=%0d, want all 0",
               bus.port_grant, bus.busy, bus.grant_idx,
               bus.xfer_abort, bus.xfer_bits);
    end
    rst_n = 1'b1;
    m_rr  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.port_data = 2'($urandom_range(0, 3));
      bus.port_val  = 2'($urandom_range(0, 3));
      bus.port_last = 2'($urandom_range(0, 3));
      #1;
      n_vec++;
      if ({bus.port_grant, bus.busy, bus.up_data,
           bus.up_val, bus.up_last} !== 5'b0) begin
        n_bad++;
        $display("FAIL idle_%0d: grant=%b busy=%b up=%b%b%b, want 0",
                 i, bus.port_grant, bus.busy, bus.up_data,
                 bus.up_val, bus.up_last);
      end
    end
    clear_lanes();
  endtask

  task automatic test_single();
    int lat;
    int p;
    logic [1:0] oh;
    logic [1:0] d;
    logic lst;
    exp_t e;
    @(negedge clk);
    bus.port_req = 2'b01;
    wait_grant(lat);
    p  = pick(2'b01, m_rr);
    oh = 2'b01 << p;
    n_vec++;
    if (lat != 1) begin
      n_bad++;
      $display("FAIL req_latency: got %0d want 1", lat);
    end
    n_vec++;
    if (bus.port_grant !== oh || bus.grant_idx !== 1'(p)) begin
      n_bad++;
      $display("FAIL single_grant: grant=%b idx=%b want %b/%0d",
               bus.port_grant, bus.grant_idx, oh, p);
    end
    sb.push_back('{p, 8, 1'b0});
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      d   = 2'($urandom_range(0, 3));
      lst = (i == 7);
      bus.port_data = d;
      bus.port_val  = {1'($urandom_range(0, 1)), 1'b1};
      bus.port_last = {1'($urandom_range(0, 1)), lst};
      #1;
      n_vec++;
      if ({bus.up_data, bus.up_val, bus.up_last} !==
          {d[0], 1'b1, lst}) begin
        n_bad++;
        $display("FAIL mux_bit%0d: up=%b%b%b want %b1%b", i,
                 bus.up_data, bus.up_val, bus.up_last, d[0], lst);
      end
    end
    @(negedge clk);
    clear_lanes();
    #1;
    e = sb.pop_front();
    n_vec++;
    if ({bus.port_grant, bus.busy, bus.xfer_abort,
         bus.xfer_bits} !== {2'b00, 1'b0, e.abort,
                             16'(e.bits)}) begin
      n_bad++;
      $display("FAIL single_end: grant=%b busy=%b abort=%b bits=%0d want 00/0/%b/%0d",
               bus.port_grant, bus.busy, bus.xfer_abort,
               bus.xfer_bits, e.abort, e.bits);
    end
    m_rr = (p + 1) % NP;
    wait_grant(lat);
    n_vec++;
    if (lat != IPG + 1) begin
      n_bad++;
      $display("FAIL gap_spacing: got %0d want %0d", lat, IPG + 1);
    end
    p  = pick(2'b01, m_rr);
    oh = 2'b01 << p;
    n_vec++;
    if (bus.port_grant !== oh) begin
      n_bad++;
      $display("FAIL regrant: got %b want %b", bus.port_grant, oh);
    end
    sb.push_back('{p, 0, 1'b1});
    bus.port_req = 2'b00;
    @(negedge clk);
    #1;
    e = sb.pop_front();
    n_vec++;
    if ({bus.port_grant, bus.xfer_abort, bus.xfer_bits} !==
        {2'b00, e.abort, 16'(e.bits)}) begin
      n_bad++;
      $display("FAIL drop_abort: grant=%b abort=%b bits=%0d want 00/%b/%0d",
               bus.port_grant, bus.xfer_abort, bus.xfer_bits,
               e.abort, e.bits);
    end
    m_rr = (p + 1) % NP;
    @(negedge clk);
    #1;
    n_vec++;
    if (bus.xfer_abort !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_width: got %b want 0", bus.xfer_abort);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int lat;
    int p;
    logic [1:0] oh;
    logic [1:0] prev;
    exp_t e;
    prev = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    bus.port_req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    m_rr  = 0;
    bus.port_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_grant(lat);
      p  = pick(2'b11, m_rr);
      oh = 2'b01 << p;
      n_vec++;
      if (bus.port_grant !== oh) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got %b want %b", k,
                 bus.port_grant, oh);
      end
      n_vec++;
      if (bus.port_grant === prev) begin
        n_bad++;
        $display("FAIL rr_repeat%0d: got %b twice", k, prev);
      end
      prev = bus.port_grant;
      sb.push_back('{p, 4, 1'b0});
      send_bits(p, 4, 1'b1);
      @(negedge clk);
      clear_lanes();
      #1;
      e = sb.pop_front();
      n_vec++;
      if ({bus.port_grant, bus.xfer_abort, bus.xfer_bits} !==
          {2'b00, e.abort, 16'(e.bits)}) begin
        n_bad++;
        $display("FAIL rr_end%0d: grant=%b abort=%b bits=%0d want 00/%b/%0d",
                 k, bus.port_grant, bus.xfer_abort,
                 bus.xfer_bits, e.abort, e.bits);
      end
      m_rr = (p + 1) % NP;
    end
    bus.port_req = 2'b00;
  endtask

  task automatic test_timeout();
    int lat;
    int p;
    int k;
    logic [1:0] oh;
    exp_t e;
    bus.port_req = 2'b10;
    wait_grant(lat);
    p  = pick(2'b10, m_rr);
    oh = 2'b01 << p;
    n_vec++;
    if (bus.port_grant !== oh) begin
      n_bad++;
      $display("FAIL to_grant: got %b want %b", bus.port_grant, oh);
    end
    sb.push_back('{p, 3, 1'b1});
    send_bits(p, 3, 1'b0);
    bus.port_req = 2'b11;
    k = 0;
    do begin
      @(negedge clk);
      clear_lanes();
      #1;
      k++;
    end while (bus.busy === 1'b1 && k < TMO + 10);
    n_vec++;
    if (k != TMO + 1) begin
      n_bad++;
      $display("FAIL to_cycles: grant dropped after %0d stall cycles, want %0d",
               k, TMO + 1);
    end
    e = sb.pop_front();
    n_vec++;
    if ({bus.port_grant, bus.xfer_abort, bus.xfer_bits} !==
        {2'b00, e.abort, 16'(e.bits)}) begin
      n_bad++;
      $display("FAIL to_end: grant=%b abort=%b bits=%0d want 00/%b/%0d",
               bus.port_grant, bus.xfer_abort, bus.xfer_bits,
               e.abort, e.bits);
    end
    m_rr = (p + 1) % NP;
    @(negedge clk);
    #1;
    n_vec++;
    if (bus.xfer_abort !== 1'b0) begin
      n_bad++;
      $display("FAIL to_pulse: abort=%b want 0", bus.xfer_abort);
    end
    wait_grant(lat);
    p  = pick(2'b11, m_rr);
    oh = 2'b01 << p;
    n_vec++;
    if (bus.port_grant !== oh) begin
      n_bad++;
      $display("FAIL to_next: got %b want %b", bus.port_grant, oh);
    end
    sb.push_back('{p, 5, 1'b0});
    send_bits(p, 5, 1'b1);
    @(negedge clk);
    clear_lanes();
    #1;
    e = sb.pop_front();
    n_vec++;
    if ({bus.port_grant, bus.xfer_abort, bus.xfer_bits} !==
        {2'b00, e.abort, 16'(e.bits)}) begin
      n_bad++;
      $display("FAIL to_next_end: grant=%b abort=%b bits=%0d want 00/%b/%0d",
               bus.port_grant, bus.xfer_abort, bus.xfer_bits,
               e.abort, e.bits);
    end
    m_rr = (p + 1) % NP;
  endtask

  task automatic test_mid_operation();
    int lat;
    int p;
    logic [1:0] oh;
    exp_t e;
    bus.port_req = 2'b11;
    wait_grant(lat);
    p  = pick(2'b11, m_rr);
    oh = 2'b01 << p;
    n_vec++;
    if (bus.port_grant !== oh) begin
      n_bad++;
      $display("FAIL mid_grant: got %b want %b", bus.port_grant, oh);
    end
    send_bits(p, 2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    clear_lanes();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if ({bus.port_grant, bus.busy, bus.xfer_abort,
         bus.xfer_bits} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: grant=%b busy=%b abort=%b bits=%0d want 0",
               bus.port_grant, bus.busy, bus.xfer_abort,
               bus.xfer_bits);
    end
    m_rr = 0;
    wait_grant(lat);
    p  = pick(2'b11, m_rr);
    oh = 2'b01 << p;
    n_vec++;
    if (bus.port_grant !== oh) begin
      n_bad++;
      $display("FAIL rr_after_reset: got %b want %b",
               bus.port_grant, oh);
    end
    sb.push_back('{p, 3, 1'b0});
    send_bits(p, 2, 1'b0);
    @(negedge clk);
    bus.port_data = 2'($urandom_range(0, 3));
    bus.port_val  = oh;
    bus.port_last = oh;
    bus.port_req  = 2'b11 & ~oh;
    #1;
    @(negedge clk);
    clear_lanes();
    bus.port_req = 2'b00;
    #1;
    e = sb.pop_front();
    n_vec++;
    if ({bus.port_grant, bus.xfer_abort, bus.xfer_bits} !==
        {2'b00, e.abort, 16'(e.bits)}) begin
      n_bad++;
      $display("FAIL last_vs_drop: grant=%b abort=%b bits=%0d want 00/%b/%0d",
               bus.port_grant, bus.xfer_abort, bus.xfer_bits,
               e.abort, e.bits);
    end
    m_rr = (p + 1) % NP;
    repeat (5) @(negedge clk);
    #1;
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL final_idle: busy=%b want 0", bus.busy);
    end
  endtask

  // Hard stop if a scenario ever wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_mid_operation();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
